// File: rtl/dc_pkg.sv
// Shared constants, time record and load-range check for the digital clock.
// DC_W sets the width of the time record; the clock's W parameter must equal it.
package dc_pkg;

    localparam int unsigned DC_W        = 8;
    localparam int unsigned SEC_MAX     = 59;
    localparam int unsigned MIN_MAX     = 59;
    localparam int unsigned HOUR12_NOON = 12;

    typedef struct packed {
        logic [DC_W-1:0] hour;
        logic [DC_W-1:0] min;
        logic [DC_W-1:0] sec;
    } dc_time_t;

    function automatic logic time_valid(input dc_time_t t, input int unsigned hours_per_day);
        return (32'(t.sec) <= SEC_MAX) && (32'(t.min) <= MIN_MAX) &&
               (32'(t.hour) < hours_per_day);
    endfunction

endpackage

// File: rtl/dc_mod_counter.sv
// Modulo-MOD counter with synchronous load (priority over inc) and a carry-out
// that is high in the cycle the count wraps from MOD-1 to 0.
module dc_mod_counter #(
    parameter int unsigned W   = 8,
    parameter int unsigned MOD = 60
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         carry
);

    logic [W-1:0] count_q, count_d;

    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        carry   = inc && (count_q == W'(MOD - 1));
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (inc) begin
            count_d = carry ? '0 : count_q + W'(1);
        end
    end

    // NOTE: state updates use <= so every flop samples pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/digital_clock_param.sv
// Parametrised 24 h binary clock: prescaler, run/pause, validated load, 12 h view, day pulse.
// Optional alarm compare/latch is compiled in when DC_ALARM_EN is defined.
module digital_clock_param
    import dc_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 1,
    parameter int unsigned HOURS_PER_DAY = 24,
    parameter int unsigned W             = DC_W
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         run,
    input  logic         set_valid,
    input  logic [W-1:0] set_hour,
    input  logic [W-1:0] set_min,
    input  logic [W-1:0] set_sec,
    output logic         set_ack,
    output logic         set_err,
    input  logic         mode_12h,
    output logic [W-1:0] sec,
    output logic [W-1:0] minute,
    output logic [W-1:0] hour,
    output logic         pm,
    output logic         tick,
    output logic         day_pulse
`ifdef DC_ALARM_EN
    ,
    input  logic         alarm_wr,
    input  logic [W-1:0] alarm_hour,
    input  logic [W-1:0] alarm_min,
    input  logic         alarm_ack,
    output logic         alarm
`endif
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, day_q, ack_q, err_q;
    logic          terminal, load_ok, load_bad, tick_ok;
    logic          sec_carry, min_carry, hour_carry;
    logic [W-1:0]  sec_q, min_q, hour_q;
    dc_time_t      set_time;

    assign set_time = '{hour: DC_W'(set_hour), min: DC_W'(set_min), sec: DC_W'(set_sec)};
    assign load_ok  = set_valid && time_valid(set_time, HOURS_PER_DAY);
    assign load_bad = set_valid && !load_ok;
    assign terminal = (pre_q == PW'(TICK_DIV - 1));
    // An accepted load swallows a coincident tick, so nothing downstream sees it.
    assign tick_ok  = run && terminal && !load_ok;

    always_comb begin
        pre_d = pre_q;
        if (load_ok) begin
            pre_d = '0;
        end else if (run) begin
            pre_d = terminal ? '0 : pre_q + PW'(1);
        end
    end

    dc_mod_counter #(.W(W), .MOD(SEC_MAX + 1)) u_sec (
        .clk(clk), .resetn(resetn), .inc(tick_ok), .load(load_ok),
        .load_val(set_sec), .count(sec_q), .carry(sec_carry)
    );

    dc_mod_counter #(.W(W), .MOD(MIN_MAX + 1)) u_min (
        .clk(clk), .resetn(resetn), .inc(sec_carry), .load(load_ok),
        .load_val(set_min), .count(min_q), .carry(min_carry)
    );

    dc_mod_counter #(.W(W), .MOD(HOURS_PER_DAY)) u_hour (
        .clk(clk), .resetn(resetn), .inc(min_carry), .load(load_ok),
        .load_val(set_hour), .count(hour_q), .carry(hour_carry)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
            day_q  <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_ok;
            day_q  <= hour_carry;
            ack_q  <= load_ok;
            err_q  <= load_bad;
        end
    end

    always_comb begin
        hour = hour_q;
        pm   = 1'b0;
        if (mode_12h) begin
            pm = (hour_q >= W'(HOUR12_NOON));
            if (hour_q == '0) begin
                hour = W'(HOUR12_NOON);
            end else if (hour_q > W'(HOUR12_NOON)) begin
                hour = hour_q - W'(HOUR12_NOON);
            end
        end
    end

    assign sec       = sec_q;
    assign minute    = min_q;
    assign tick      = tick_q;
    assign day_pulse = day_q;
    assign set_ack   = ack_q;
    assign set_err   = err_q;

`ifdef DC_ALARM_EN
    dc_time_t     alarm_time_q, alarm_time_d;
    logic         alarm_q, alarm_d, match;
    logic [W-1:0] min_nxt, hour_nxt;

    // A match needs seconds wrapping to 00, which only a real tick can do; loads never match.
    always_comb begin
        min_nxt      = min_carry ? '0 : min_q + W'(1);
        hour_nxt     = min_carry ? (hour_carry ? '0 : hour_q + W'(1)) : hour_q;
        match        = sec_carry && (min_nxt == W'(alarm_time_q.min)) &&
                       (hour_nxt == W'(alarm_time_q.hour));
        alarm_time_d = alarm_time_q;
        if (alarm_wr) begin
            alarm_time_d = '{hour: DC_W'(alarm_hour), min: DC_W'(alarm_min), sec: '0};
        end
        alarm_d = alarm_q;
        if (match) begin
            alarm_d = 1'b1;
        end else if (alarm_ack) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alarm_time_q <= '0;
            alarm_q      <= 1'b0;
        end else begin
            alarm_time_q <= alarm_time_d;
            alarm_q      <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_digital_clock_param.sv
// Directed bench: dut_a (TICK_DIV=1, 2-hour day) for day rollover, dut_b (TICK_DIV=4) for the rest.
module tb_digital_clock_param;

    localparam int W = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // dut_a: free-running, never loaded
    logic         a_run = 1'b1, a_set_valid = 1'b0, a_mode = 1'b0;
    logic [W-1:0] a_set_hour = '0, a_set_min = '0, a_set_sec = '0;
    logic [W-1:0] a_sec, a_min, a_hour;
    logic         a_ack, a_err, a_pm, a_tick, a_day;

    // dut_b: directed stimulus
    logic         b_run = 1'b1, b_set_valid = 1'b0, b_mode = 1'b1;
    logic [W-1:0] b_set_hour = '0, b_set_min = '0, b_set_sec = '0;
    logic [W-1:0] b_sec, b_min, b_hour;
    logic         b_ack, b_err, b_pm, b_tick, b_day;

`ifdef DC_ALARM_EN
    logic         a_alarm, b_alarm;
    logic         b_alarm_wr = 1'b0, b_alarm_ack = 1'b0;
    logic [W-1:0] b_alarm_hour = '0, b_alarm_min = '0;
`endif

    digital_clock_param #(.TICK_DIV(1), .HOURS_PER_DAY(2), .W(W)) dut_a (
        .clk(clk), .resetn(resetn), .run(a_run), .set_valid(a_set_valid),
        .set_hour(a_set_hour), .set_min(a_set_min), .set_sec(a_set_sec),
        .set_ack(a_ack), .set_err(a_err), .mode_12h(a_mode),
        .sec(a_sec), .minute(a_min), .hour(a_hour), .pm(a_pm),
        .tick(a_tick), .day_pulse(a_day)
`ifdef DC_ALARM_EN
        , .alarm_wr(1'b0), .alarm_hour(8'd0), .alarm_min(8'd0),
        .alarm_ack(1'b0), .alarm(a_alarm)
`endif
    );

    digital_clock_param #(.TICK_DIV(4), .HOURS_PER_DAY(24), .W(W)) dut_b (
        .clk(clk), .resetn(resetn), .run(b_run), .set_valid(b_set_valid),
        .set_hour(b_set_hour), .set_min(b_set_min), .set_sec(b_set_sec),
        .set_ack(b_ack), .set_err(b_err), .mode_12h(b_mode),
        .sec(b_sec), .minute(b_min), .hour(b_hour), .pm(b_pm),
        .tick(b_tick), .day_pulse(b_day)
`ifdef DC_ALARM_EN
        , .alarm_wr(b_alarm_wr), .alarm_hour(b_alarm_hour), .alarm_min(b_alarm_min),
        .alarm_ack(b_alarm_ack), .alarm(b_alarm)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_b_time(input string tag, input int h, input int m, input int s);
        check({tag, ".hour"}, 32'(b_hour), 32'(h));
        check({tag, ".min"},  32'(b_min),  32'(m));
        check({tag, ".sec"},  32'(b_sec),  32'(s));
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Presents a load for one edge; returns at the negedge where ack/err are visible.
    task automatic load_b(input int h, input int m, input int s);
        b_set_hour  = W'(h);
        b_set_min   = W'(m);
        b_set_sec   = W'(s);
        b_set_valid = 1'b1;
        cyc();
        b_set_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int day_cnt;
        int tick_cnt;
        int frozen_bad;

        // Reset state: dut_a in 24 h view, dut_b in 12 h view
        cyc(2);
        check("rst_a.hour", 32'(a_hour), 0);
        check("rst_a.sec",  32'(a_sec), 0);
        check("rst_a.day",  32'(a_day), 0);
        check("rst_b.hour12", 32'(b_hour), 12);
        check("rst_b.pm",   32'(b_pm), 0);
        check("rst_b.min",  32'(b_min), 0);
        check("rst_b.tick", 32'(b_tick), 0);
        check("rst_b.ack",  32'(b_ack), 0);
`ifdef DC_ALARM_EN
        check("rst_b.alarm", 32'(b_alarm), 0);
`endif
        resetn = 1'b1;
        b_mode = 1'b0;

        // Two full 7200-second days at one tick per clk
        day_cnt = 0;
        for (int i = 0; i < 14400; i++) begin
            cyc();
            if (a_day) day_cnt++;
        end
        check("a.day_count", 32'(day_cnt), 2);
        check("a.final_hour", 32'(a_hour), 0);
        check("a.final_min",  32'(a_min), 0);
        check("a.final_sec",  32'(a_sec), 0);

        // Load 23:59:58, rollover with TICK_DIV=4
        load_b(23, 59, 58);
        check("ld1.ack", 32'(b_ack), 1);
        check("ld1.err", 32'(b_err), 0);
        check_b_time("ld1", 23, 59, 58);
        cyc(3);
        check("ld1.p3.sec",  32'(b_sec), 58);
        check("ld1.p3.tick", 32'(b_tick), 0);
        check("ld1.p3.ack",  32'(b_ack), 0);
        cyc();
        check("ld1.p4.sec",  32'(b_sec), 59);
        check("ld1.p4.tick", 32'(b_tick), 1);
        cyc(3);
        check("ld1.p7.day",  32'(b_day), 0);
        cyc();
        check_b_time("wrap", 0, 0, 0);
        check("wrap.day",  32'(b_day), 1);
        check("wrap.tick", 32'(b_tick), 1);
        cyc();
        check("wrap+1.day",  32'(b_day), 0);
        check("wrap+1.tick", 32'(b_tick), 0);

        // Invalid minute: time unchanged, error pulse only
        load_b(10, 60, 0);
        check("bad_min.err", 32'(b_err), 1);
        check("bad_min.ack", 32'(b_ack), 0);
        check_b_time("bad_min", 0, 0, 0);
        cyc();
        check("bad_min+1.err", 32'(b_err), 0);
        cyc();
        check("bad_min.tick_continues", 32'(b_sec), 1);

        // Pause with prescaler at 1, then resume from there
        cyc();
        b_run = 1'b0;
        tick_cnt = 0;
        frozen_bad = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (b_tick) tick_cnt++;
            if (b_sec != 8'd1 || b_min != 8'd0 || b_hour != 8'd0) frozen_bad++;
        end
        check("pause.ticks", 32'(tick_cnt), 0);
        check("pause.changed_cycles", 32'(frozen_bad), 0);
        b_run = 1'b1;
        cyc(2);
        check("resume.p2.sec", 32'(b_sec), 1);
        cyc();
        check("resume.p3.sec",  32'(b_sec), 2);
        check("resume.p3.tick", 32'(b_tick), 1);

        // 12 h view across noon and midnight
        b_mode = 1'b1;
        load_b(11, 59, 59);
        check("h12.pre.hour", 32'(b_hour), 11);
        check("h12.pre.pm",   32'(b_pm), 0);
        cyc(4);
        check_b_time("h12.noon", 12, 0, 0);
        check("h12.noon.pm", 32'(b_pm), 1);
        load_b(0, 30, 0);
        check("h12.mid.hour", 32'(b_hour), 12);
        check("h12.mid.pm",   32'(b_pm), 0);
        load_b(13, 5, 0);
        check("h12.13.hour", 32'(b_hour), 1);
        check("h12.13.pm",   32'(b_pm), 1);
        b_mode = 1'b0;
        cyc();
        check("h24.13.hour", 32'(b_hour), 13);
        check("h24.13.pm",   32'(b_pm), 0);

        // Load coinciding with the terminal count: load wins, no tick/day pulse
        load_b(23, 59, 59);
        cyc(3);
        load_b(5, 6, 7);
        check("coll.ack",  32'(b_ack), 1);
        check("coll.tick", 32'(b_tick), 0);
        check("coll.day",  32'(b_day), 0);
        check_b_time("coll", 5, 6, 7);
        cyc(3);
        check("coll.p3.sec", 32'(b_sec), 7);
        cyc();
        check("coll.p4.sec", 32'(b_sec), 8);

        // Held set_valid: one pulse per cycle; range boundaries
        b_set_hour = 8'd1; b_set_min = 8'd2; b_set_sec = 8'd3;
        b_set_valid = 1'b1;
        cyc();
        check("hold1.ack", 32'(b_ack), 1);
        cyc();
        check("hold2.ack", 32'(b_ack), 1);
        check_b_time("hold2", 1, 2, 3);
        b_set_hour = 8'd24;
        cyc();
        check("bad_hour.err", 32'(b_err), 1);
        check("bad_hour.ack", 32'(b_ack), 0);
        check_b_time("bad_hour", 1, 2, 3);
        b_set_hour = 8'd0; b_set_sec = 8'd60;
        cyc();
        check("bad_sec.err", 32'(b_err), 1);
        b_set_valid = 1'b0;
        cyc();
        check("idle.err", 32'(b_err), 0);
        check("idle.ack", 32'(b_ack), 0);

        // Load while paused
        b_run = 1'b0;
        load_b(8, 0, 0);
        check("paused_ld.ack", 32'(b_ack), 1);
        cyc(5);
        check_b_time("paused_ld", 8, 0, 0);
        b_run = 1'b1;

`ifdef DC_ALARM_EN
        b_alarm_hour = 8'd7; b_alarm_min = 8'd0; b_alarm_wr = 1'b1;
        cyc();
        b_alarm_wr = 1'b0;
        load_b(6, 59, 59);
        check("al.pre", 32'(b_alarm), 0);
        cyc(3);
        check("al.p3", 32'(b_alarm), 0);
        cyc();
        check_b_time("al.hit", 7, 0, 0);
        check("al.hit", 32'(b_alarm), 1);
        cyc();
        check("al.hold", 32'(b_alarm), 1);
        load_b(6, 59, 59);
        check("al.load_keeps", 32'(b_alarm), 1);
        cyc(3);
        b_alarm_ack = 1'b1;
        cyc();
        check("al.ack_and_match", 32'(b_alarm), 1);
        cyc();
        check("al.acked", 32'(b_alarm), 0);
        b_alarm_ack = 1'b0;
        load_b(7, 0, 0);
        check("al.load_on_match", 32'(b_alarm), 0);
        cyc();
        check("al.load_on_match+1", 32'(b_alarm), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
